// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: data word, arbiter FSM states and
// requester identities (the latter also serves as the round-robin pointer).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    GNT_D,
    GNT_I0,
    GNT_I1
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_D,
    REQ_I0,
    REQ_I1
  } arb_req_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the requesters (D, I0, I1), the arbiter and the RAM port.
// master = arbiter view, slave = requester/RAM view.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic            dREN;
  logic            dWEN;
  logic            dlock;
  word_t           daddr;
  word_t           dstore;
  logic            dwait;
  word_t           dload;

  logic [1:0]      iREN;
  word_t [1:0]     iaddr;
  logic [1:0]      iwait;
  word_t [1:0]     iload;

  logic            ramREN;
  logic            ramWEN;
  word_t           ramaddr;
  word_t           ramstore;
  word_t           ramload;
  logic            ramwait;

  modport master (
    input  dREN, dWEN, dlock, daddr, dstore, iREN, iaddr, ramload, ramwait,
    output dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output dREN, dWEN, dlock, daddr, dstore, iREN, iaddr, ramload, ramwait,
    input  dwait, dload, iwait, iload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of D grants served while an icache waits; clear wins over
// increment, and limit_o flags when an icache must be served next.
module arb_starve_counter #(
  parameter int CNT_W        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] Limit  = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = (cnt_q >= Limit);

endmodule

// File: rtl/memory_arbiter.sv
// Three-way RAM port arbiter: D fixed priority with block lock, I0/I1 round
// robin, starvation guard. Define ARB_PERF_CNT_EN for per-requester grant counters.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  memory_arbiter_if.master  bus
`ifdef ARB_PERF_CNT_EN
  ,
  output word_t             gnt_cnt_d,
  output word_t             gnt_cnt_i0,
  output word_t             gnt_cnt_i1
`endif
);

  arb_state_t state_q, state_d;
  arb_req_t   rr_q, rr_d;
  arb_state_t i_pick;
  logic       any_i, d_req, starved, d_done, i_done, i_idx;

  assign any_i = |bus.iREN;
  assign d_req = bus.dREN | bus.dWEN;
  assign i_idx = (state_q == GNT_I1);

  // Pointer's icache if it asks, otherwise the other one.
  always_comb begin
    i_pick = GNT_I1;
    if ((rr_q == REQ_I0 && bus.iREN[0]) || (rr_q == REQ_I1 && !bus.iREN[1])) begin
      i_pick = GNT_I0;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    d_done       = 1'b0;
    i_done       = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.dwait    = 1'b1;
    bus.iwait    = 2'b11;
    bus.dload    = '0;
    bus.iload    = '0;
    case (state_q)
      IDLE: begin
        if (starved && any_i)  state_d = i_pick;
        else if (d_req)        state_d = GNT_D;
        else if (any_i)        state_d = i_pick;
      end
      GNT_D: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dload    = bus.ramload;
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          bus.ramWEN = bus.dWEN;
          bus.ramREN = bus.dREN & ~bus.dWEN;
          if (!bus.ramwait) begin
            bus.dwait = 1'b0;
            d_done    = 1'b1;
            state_d   = bus.dlock ? GNT_D : IDLE;
          end
        end
      end
      GNT_I0, GNT_I1: begin
        bus.ramaddr       = bus.iaddr[i_idx];
        bus.iload[i_idx]  = bus.ramload;
        if (!bus.iREN[i_idx]) begin
          state_d = IDLE;
        end else begin
          bus.ramREN = 1'b1;
          if (!bus.ramwait) begin
            bus.iwait[i_idx] = 1'b0;
            i_done           = 1'b1;
            state_d          = IDLE;
            rr_d             = i_idx ? REQ_I0 : REQ_I1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      rr_q    <= REQ_I0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  arb_starve_counter #(
    .CNT_W        (CNT_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .inc_i   (d_done & any_i),
    .clr_i   (i_done),
    .limit_o (starved)
  );

`ifdef ARB_PERF_CNT_EN
  word_t cnt_d_q, cnt_i0_q, cnt_i1_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_d_q  <= '0;
      cnt_i0_q <= '0;
      cnt_i1_q <= '0;
    end else begin
      if (d_done)            cnt_d_q  <= cnt_d_q + 32'd1;
      if (i_done && !i_idx)  cnt_i0_q <= cnt_i0_q + 32'd1;
      if (i_done && i_idx)   cnt_i1_q <= cnt_i1_q + 32'd1;
    end
  end

  assign gnt_cnt_d  = cnt_d_q;
  assign gnt_cnt_i0 = cnt_i0_q;
  assign gnt_cnt_i1 = cnt_i1_q;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a grant-level reference model checked every
// cycle, plus literal checks on completion order, addresses and boundary cases.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int OWN_NONE = 0;
  localparam int OWN_D    = 1;
  localparam int OWN_I0   = 2;
  localparam int OWN_I1   = 3;
  localparam int LIMIT    = 4;
  localparam int SAT      = 7;

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  memory_arbiter_if bus ();

`ifdef ARB_PERF_CNT_EN
  word_t gnt_cnt_d, gnt_cnt_i0, gnt_cnt_i1;
`endif

  memory_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .CNT_W        (3)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .gnt_cnt_d  (gnt_cnt_d),
    .gnt_cnt_i0 (gnt_cnt_i0),
    .gnt_cnt_i1 (gnt_cnt_i1)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the port, round-robin pointer, starvation count.
  int    owner, rr, starve;
  bit    valid = 1'b0;
  int    n_done_d, n_done_i0, n_done_i1;
  // Completions actually observed on the DUT: 0 = D, 1 = I0, 2 = I1.
  int    log_src[$];
  word_t log_addr[$];

  function automatic int pick_i(input int ptr, input logic [1:0] req);
    if (req[ptr]) return OWN_I0 + ptr;
    return OWN_I0 + (1 - ptr);
  endfunction

  always @(negedge CLK) begin
    logic       e_ren, e_wen, e_dwait;
    logic [1:0] e_iwait;
    word_t      e_addr, e_store, e_dload, e_il0, e_il1;
    int         nxt, x;
    bit         dd, idn;

    e_ren = 0; e_wen = 0; e_dwait = 1; e_iwait = 2'b11;
    e_addr = '0; e_store = '0; e_dload = '0; e_il0 = '0; e_il1 = '0;
    nxt = owner; x = 0; dd = 0; idn = 0;

    if (owner == OWN_NONE) begin
      if (starve >= LIMIT && |bus.iREN)     nxt = pick_i(rr, bus.iREN);
      else if (bus.dREN || bus.dWEN)        nxt = OWN_D;
      else if (|bus.iREN)                   nxt = pick_i(rr, bus.iREN);
    end else if (owner == OWN_D) begin
      e_addr = bus.daddr; e_store = bus.dstore; e_dload = bus.ramload;
      if (!(bus.dREN || bus.dWEN)) nxt = OWN_NONE;
      else begin
        e_wen = bus.dWEN;
        e_ren = bus.dREN && !bus.dWEN;
        if (!bus.ramwait) begin
          e_dwait = 0; dd = 1;
          nxt = bus.dlock ? OWN_D : OWN_NONE;
        end
      end
    end else begin
      x = owner - OWN_I0;
      e_addr = bus.iaddr[x];
      if (x == 0) e_il0 = bus.ramload; else e_il1 = bus.ramload;
      if (!bus.iREN[x]) nxt = OWN_NONE;
      else begin
        e_ren = 1;
        if (!bus.ramwait) begin
          e_iwait[x] = 1'b0; idn = 1; nxt = OWN_NONE;
        end
      end
    end

    if (valid) begin
      check("ramREN",   bus.ramREN,   e_ren);
      check("ramWEN",   bus.ramWEN,   e_wen);
      check("ramaddr",  bus.ramaddr,  e_addr);
      check("ramstore", bus.ramstore, e_store);
      check("dwait",    bus.dwait,    e_dwait);
      check("iwait",    bus.iwait,    e_iwait);
      check("dload",    bus.dload,    e_dload);
      check("iload0",   bus.iload[0], e_il0);
      check("iload1",   bus.iload[1], e_il1);
      if (bus.dwait === 1'b0)    begin log_src.push_back(0); log_addr.push_back(bus.ramaddr); end
      if (bus.iwait[0] === 1'b0) begin log_src.push_back(1); log_addr.push_back(bus.ramaddr); end
      if (bus.iwait[1] === 1'b0) begin log_src.push_back(2); log_addr.push_back(bus.ramaddr); end
    end

    if (!nRST) begin
      owner = OWN_NONE; rr = 0; starve = 0; valid = 1'b1;
      n_done_d = 0; n_done_i0 = 0; n_done_i1 = 0;
    end else begin
      owner = nxt;
      if (dd) begin
        n_done_d++;
        if (|bus.iREN) starve = (starve < SAT) ? starve + 1 : SAT;
      end
      if (idn) begin
        starve = 0;
        rr = 1 - x;
        if (x == 0) n_done_i0++; else n_done_i1++;
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clear_log();
    log_src.delete();
    log_addr.delete();
  endtask

  task automatic expect_done(input string name, input int idx, input int src, input word_t addr);
    int    a_src;
    word_t a_addr;
    a_src  = (idx < log_src.size()) ? log_src[idx]  : -1;
    a_addr = (idx < log_src.size()) ? log_addr[idx] : 32'hFFFF_FFFF;
    check({name, "_src"},  a_src,  src);
    check({name, "_addr"}, a_addr, addr);
  endtask

  initial begin
    bus.dREN = 0; bus.dWEN = 0; bus.dlock = 0; bus.daddr = '0; bus.dstore = '0;
    bus.iREN = 2'b00; bus.iaddr[0] = '0; bus.iaddr[1] = '0;
    bus.ramload = '0; bus.ramwait = 0;
    nRST = 0;

    // Reset state
    step(2);
    @(negedge CLK);
    check("rst_dwait",  bus.dwait,  1'b1);
    check("rst_iwait",  bus.iwait,  2'b11);
    check("rst_ramREN", bus.ramREN, 1'b0);
    step();
    nRST = 1;

    // Single D read: one bubble cycle, then completion
    clear_log();
    bus.ramload = 32'h1111_0040; bus.daddr = 32'h40; bus.dREN = 1;
    @(negedge CLK);
    check("t1_bubble_ren", bus.ramREN, 1'b0);
    step();
    @(negedge CLK);
    check("t1_ramREN", bus.ramREN,  1'b1);
    check("t1_addr",   bus.ramaddr, 32'h40);
    check("t1_dwait",  bus.dwait,   1'b0);
    check("t1_dload",  bus.dload,   32'h1111_0040);
    step();
    bus.dREN = 0;
    step(2);
    check("t1_count", log_src.size(), 1);

    // Locked two-word D block while I0 waits
    clear_log();
    bus.ramload = 32'h2222_0000; bus.iaddr[0] = 32'h200; bus.iREN = 2'b01;
    bus.daddr = 32'h100; bus.dlock = 1; bus.dREN = 1;
    step(2);
    bus.daddr = 32'h104; bus.dlock = 0;
    step();
    bus.dREN = 0;
    step(2);
    bus.iREN = 2'b00;
    step(2);
    check("t2_count", log_src.size(), 3);
    expect_done("t2_w0", 0, 0, 32'h100);
    expect_done("t2_w1", 1, 0, 32'h104);
    expect_done("t2_i0", 2, 1, 32'h200);

    // Both icaches continuously: strict alternation starting at I0
    nRST = 0;
    step();
    nRST = 1;
    clear_log();
    bus.ramload = 32'h3333_3333; bus.iaddr[0] = 32'h1000; bus.iaddr[1] = 32'h2000;
    bus.iREN = 2'b11;
    step(8);
    bus.iREN = 2'b00;
    step(2);
    check("t3_count", log_src.size(), 4);
    expect_done("t3_g0", 0, 1, 32'h1000);
    expect_done("t3_g1", 1, 2, 32'h2000);
    expect_done("t3_g2", 2, 1, 32'h1000);
    expect_done("t3_g3", 3, 2, 32'h2000);

    // Starvation: four D grants, one I1 grant, then D again
    clear_log();
    bus.ramload = 32'h4444_0000; bus.daddr = 32'h600; bus.dREN = 1; bus.iREN = 2'b10;
    step(12);
    bus.dREN = 0; bus.iREN = 2'b00;
    step(2);
    check("t4_count", log_src.size(), 6);
    for (int k = 0; k < 4; k++) expect_done("t4_d", k, 0, 32'h600);
    expect_done("t4_i1", 4, 2, 32'h2000);
    expect_done("t4_d5", 5, 0, 32'h600);

    // D withdraws while RAM is busy: no completion pulse
    clear_log();
    bus.daddr = 32'h300; bus.dREN = 1; bus.ramwait = 1;
    step();
    @(negedge CLK);
    check("t5_busy_ren", bus.ramREN, 1'b1);
    check("t5_busy_dw",  bus.dwait,  1'b1);
    step();
    bus.dREN = 0;
    @(negedge CLK);
    check("t5_drop_ren", bus.ramREN, 1'b0);
    check("t5_drop_dw",  bus.dwait,  1'b1);
    step();
    bus.ramwait = 0;
    step();
    check("t5_count", log_src.size(), 0);

    // Read and write together: write wins
    clear_log();
    bus.daddr = 32'h500; bus.dstore = 32'hCAFE_F00D; bus.dREN = 1; bus.dWEN = 1;
    step();
    @(negedge CLK);
    check("t6_wen",   bus.ramWEN,   1'b1);
    check("t6_ren",   bus.ramREN,   1'b0);
    check("t6_store", bus.ramstore, 32'hCAFE_F00D);
    step();
    bus.dREN = 0; bus.dWEN = 0;
    step(2);
    check("t6_count", log_src.size(), 1);

    // Pre-load the starve counter with two D grants under icache pressure
    bus.daddr = 32'h700; bus.dREN = 1; bus.iREN = 2'b10;
    step(4);
    bus.dREN = 0;

    // Reset in the middle of an I0 grant
    clear_log();
    bus.iaddr[0] = 32'h1000; bus.iREN = 2'b01; bus.ramwait = 1;
    step();
    nRST = 0;
    @(negedge CLK);
    check("t7_gnt_ren",  bus.ramREN,  1'b1);
    check("t7_gnt_addr", bus.ramaddr, 32'h1000);
    step();
    @(negedge CLK);
    check("t7_rst_ren",   bus.ramREN, 1'b0);
    check("t7_rst_iwait", bus.iwait,  2'b11);
    check("t7_count",     log_src.size(), 0);
    nRST = 1; bus.iREN = 2'b00; bus.ramwait = 0;
    step(2);

    // Counter restarted from zero: four D grants before I1 again
    clear_log();
    bus.daddr = 32'h800; bus.dREN = 1; bus.iREN = 2'b10;
    step(10);
    bus.dREN = 0; bus.iREN = 2'b00;
    step(2);
    check("t8_count", log_src.size(), 5);
    expect_done("t8_d3", 3, 0, 32'h800);
    expect_done("t8_i1", 4, 2, 32'h2000);

`ifdef ARB_PERF_CNT_EN
    check("perf_d",  gnt_cnt_d,  n_done_d);
    check("perf_i0", gnt_cnt_i0, n_done_i0);
    check("perf_i1", gnt_cnt_i1, n_done_i1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
